// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - opcode, ALU code and operand-select constants plus the decoded-field record
package decode_stage_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [5:0] ALU_LUI  = 6'd0;
  localparam logic [5:0] ALU_JAL  = 6'd1;
  localparam logic [5:0] ALU_JALR = 6'd2;
  localparam logic [5:0] ALU_BEQ  = 6'd3;
  localparam logic [5:0] ALU_BNE  = 6'd4;
  localparam logic [5:0] ALU_BLT  = 6'd5;
  localparam logic [5:0] ALU_BGE  = 6'd6;
  localparam logic [5:0] ALU_BLTU = 6'd7;
  localparam logic [5:0] ALU_BGEU = 6'd8;
  localparam logic [5:0] ALU_LB   = 6'd9;
  localparam logic [5:0] ALU_LH   = 6'd10;
  localparam logic [5:0] ALU_LW   = 6'd11;
  localparam logic [5:0] ALU_LBU  = 6'd12;
  localparam logic [5:0] ALU_LHU  = 6'd13;
  localparam logic [5:0] ALU_SB   = 6'd14;
  localparam logic [5:0] ALU_SH   = 6'd15;
  localparam logic [5:0] ALU_SW   = 6'd16;
  localparam logic [5:0] ALU_ADD  = 6'd17;
  localparam logic [5:0] ALU_SUB  = 6'd18;
  localparam logic [5:0] ALU_XOR  = 6'd19;
  localparam logic [5:0] ALU_OR   = 6'd20;
  localparam logic [5:0] ALU_AND  = 6'd21;
  localparam logic [5:0] ALU_SLT  = 6'd22;
  localparam logic [5:0] ALU_SLTU = 6'd23;
  localparam logic [5:0] ALU_SLL  = 6'd24;
  localparam logic [5:0] ALU_SRL  = 6'd25;
  localparam logic [5:0] ALU_SRA  = 6'd26;
  localparam logic [5:0] ALU_NOP  = 6'd63;

  typedef enum logic [1:0] {
    SEL_REG  = 2'd0,
    SEL_IMM  = 2'd1,
    SEL_PC   = 2'd2,
    SEL_ZERO = 2'd3
  } op_sel_t;

  typedef struct packed {
    logic [5:0]  alucode;
    op_sel_t     op1_sel;
    op_sel_t     op2_sel;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        reg_we;
    logic        is_load;
    logic        is_store;
    logic        illegal;
  } dec_fields_t;

  localparam dec_fields_t DEC_RESET = '{
    alucode: ALU_NOP, op1_sel: SEL_REG, op2_sel: SEL_REG,
    rs1: 5'd0, rs2: 5'd0, rd: 5'd0, imm: 32'd0,
    reg_we: 1'b0, is_load: 1'b0, is_store: 1'b0, illegal: 1'b0
  };

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side and execute-side handshake plus decoded fields of the decode stage
interface decode_stage_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_insn;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [5:0]  alucode;
  logic [1:0]  op1_sel;
  logic [1:0]  op2_sel;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        reg_we;
  logic        is_load;
  logic        is_store;
  logic [31:0] decode_cnt;
  logic        illegal;

  modport slave (
    input  in_valid, in_pc, in_insn, flush, out_ready,
    output in_ready, out_valid, out_pc, alucode, op1_sel, op2_sel,
           rs1, rs2, rd, imm, reg_we, is_load, is_store, decode_cnt, illegal
  );

  modport master (
    output in_valid, in_pc, in_insn, flush, out_ready,
    input  in_ready, out_valid, out_pc, alucode, op1_sel, op2_sel,
           rs1, rs2, rd, imm, reg_we, is_load, is_store, decode_cnt, illegal
  );

endinterface

// File: rtl/decode_stage_decoder_comb.sv
// rtl/decode_stage_decoder_comb.sv - combinational RV32I field decode; DECODE_ILLEGAL_TRAP_EN enables the illegal flag
module decoder_comb
  import decode_stage_pkg::*;
(
  input  logic [31:0] insn,
  output dec_fields_t dec
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        known;

  assign opcode = insn[6:0];
  assign funct3 = insn[14:12];
  assign funct7 = insn[31:25];
  assign imm_i  = {{20{insn[31]}}, insn[31:20]};
  assign imm_s  = {{20{insn[31]}}, insn[31:25], insn[11:7]};
  assign imm_b  = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
  assign imm_u  = {insn[31:12], 12'd0};
  assign imm_j  = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

  always_comb begin
    dec     = DEC_RESET;
    dec.rs1 = insn[19:15];
    dec.rs2 = insn[24:20];
    dec.rd  = insn[11:7];
    known   = 1'b1;
    case (opcode)
      OP_OPIMM, OP_OP: begin
        dec.reg_we = ENABLE;
        if (opcode == OP_OPIMM) begin
          dec.op2_sel = SEL_IMM;
          dec.imm     = imm_i;
        end
        case (funct3)
          3'b000: dec.alucode = (opcode == OP_OP && funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001: dec.alucode = ALU_SLL;
          3'b010: dec.alucode = ALU_SLT;
          3'b011: dec.alucode = ALU_SLTU;
          3'b100: dec.alucode = ALU_XOR;
          3'b101: dec.alucode = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110: dec.alucode = ALU_OR;
          default: dec.alucode = ALU_AND;
        endcase
        // funct7 is an immediate for non-shift OP-IMM; otherwise only 0x00/0x20 exist
        if (opcode == OP_OP || funct3 == 3'b001 || funct3 == 3'b101) begin
          if ((funct7 & 7'b1011111) != 7'd0) known = 1'b0;
          if (funct7[5] && !(funct3 == 3'b101 || (opcode == OP_OP && funct3 == 3'b000)))
            known = 1'b0;
        end
      end
      OP_LUI: begin
        dec.alucode = ALU_LUI;
        dec.op2_sel = SEL_IMM;
        dec.imm     = imm_u;
        dec.reg_we  = ENABLE;
      end
      OP_AUIPC: begin
        dec.alucode = ALU_ADD;
        dec.op1_sel = SEL_PC;
        dec.op2_sel = SEL_IMM;
        dec.imm     = imm_u;
        dec.reg_we  = ENABLE;
      end
      OP_JAL: begin
        dec.alucode = ALU_JAL;
        dec.op2_sel = SEL_PC;
        dec.imm     = imm_j;
        dec.reg_we  = ENABLE;
      end
      OP_JALR: begin
        dec.alucode = ALU_JALR;
        dec.op2_sel = SEL_PC;
        dec.imm     = imm_i;
        dec.reg_we  = ENABLE;
        known       = (funct3 == 3'b000);
      end
      OP_BRANCH: begin
        dec.imm = imm_b;
        case (funct3)
          3'b000: dec.alucode = ALU_BEQ;
          3'b001: dec.alucode = ALU_BNE;
          3'b100: dec.alucode = ALU_BLT;
          3'b101: dec.alucode = ALU_BGE;
          3'b110: dec.alucode = ALU_BLTU;
          3'b111: dec.alucode = ALU_BGEU;
          default: known = 1'b0;
        endcase
      end
      OP_LOAD: begin
        dec.op2_sel = SEL_IMM;
        dec.imm     = imm_i;
        dec.reg_we  = ENABLE;
        dec.is_load = ENABLE;
        case (funct3)
          3'b000: dec.alucode = ALU_LB;
          3'b001: dec.alucode = ALU_LH;
          3'b010: dec.alucode = ALU_LW;
          3'b100: dec.alucode = ALU_LBU;
          3'b101: dec.alucode = ALU_LHU;
          default: known = 1'b0;
        endcase
      end
      OP_STORE: begin
        dec.op2_sel  = SEL_IMM;
        dec.imm      = imm_s;
        dec.is_store = ENABLE;
        case (funct3)
          3'b000: dec.alucode = ALU_SB;
          3'b001: dec.alucode = ALU_SH;
          3'b010: dec.alucode = ALU_SW;
          default: known = 1'b0;
        endcase
      end
      default: known = 1'b0;
    endcase
    if (!known) begin
      dec.alucode  = ALU_NOP;
      dec.reg_we   = DISABLE;
      dec.is_load  = DISABLE;
      dec.is_store = DISABLE;
    end
    if (dec.rd == 5'd0) dec.reg_we = DISABLE;
`ifdef DECODE_ILLEGAL_TRAP_EN
    dec.illegal = !known;
`else
    dec.illegal = 1'b0;
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - one-entry decode pipeline register with valid/ready, flush and accept counter
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  decode_stage_if.slave  bus
);

  dec_fields_t dec;
  dec_fields_t fields_d, fields_q;
  logic        out_valid_d, out_valid_q;
  logic [31:0] pc_d, pc_q;
  logic [31:0] cnt_d, cnt_q;
  logic        in_ready;
  logic        accept;

  decoder_comb u_decoder (
    .insn (bus.in_insn),
    .dec  (dec)
  );

  assign in_ready = !bus.flush && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    fields_d    = fields_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    // in_ready is already low during flush, so accept cannot fire alongside it
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      fields_d    = dec;
      pc_d        = bus.in_pc;
      cnt_d       = cnt_q + 32'd1;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fields_q    <= DEC_RESET;
      pc_q        <= RESET_PC;
      cnt_q       <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      fields_q    <= fields_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_pc     = pc_q;
  assign bus.alucode    = fields_q.alucode;
  assign bus.op1_sel    = fields_q.op1_sel;
  assign bus.op2_sel    = fields_q.op2_sel;
  assign bus.rs1        = fields_q.rs1;
  assign bus.rs2        = fields_q.rs2;
  assign bus.rd         = fields_q.rd;
  assign bus.imm        = fields_q.imm;
  assign bus.reg_we     = fields_q.reg_we;
  assign bus.is_load    = fields_q.is_load;
  assign bus.is_store   = fields_q.is_store;
  assign bus.decode_cnt = cnt_q;
  assign bus.illegal    = fields_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0040;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [31:0] exp_cnt;

  decode_stage_if bus ();

  decode_stage #(.RESET_PC(TB_RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] insn, input logic rdy);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_insn   = insn;
    bus.out_ready = rdy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    step();
    step();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid act=%0d exp=0", bus.out_valid); end
    checks++; if (bus.decode_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt act=%0d exp=0", bus.decode_cnt); end
    checks++; if (bus.out_pc !== TB_RESET_PC) begin failures++; $display("FAIL reset_pc act=%h exp=%h", bus.out_pc, TB_RESET_PC); end
    checks++; if (bus.alucode !== ALU_NOP) begin failures++; $display("FAIL reset_alucode act=%0d exp=%0d", bus.alucode, ALU_NOP); end
    checks++; if ({bus.op1_sel, bus.op2_sel, bus.rs1, bus.rs2, bus.rd} !== 19'd0) begin failures++; $display("FAIL reset_sel_regs act=%h exp=0", {bus.op1_sel, bus.op2_sel, bus.rs1, bus.rs2, bus.rd}); end
    checks++; if (bus.imm !== 32'd0) begin failures++; $display("FAIL reset_imm act=%h exp=0", bus.imm); end
    checks++; if ({bus.reg_we, bus.is_load, bus.is_store, bus.illegal} !== 4'd0) begin failures++; $display("FAIL reset_flags act=%b exp=0000", {bus.reg_we, bus.is_load, bus.is_store, bus.illegal}); end
    rst_n = 1'b1;
    exp_cnt = 32'd0;
  endtask

  task automatic test_addi();
    drive(1'b1, 32'h0, 32'h00500093, 1'b1);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL addi_in_ready act=%0d exp=1", bus.in_ready); end
    step();
    exp_cnt = exp_cnt + 1;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL addi_out_valid act=%0d exp=1", bus.out_valid); end
    checks++; if (bus.alucode !== ALU_ADD) begin failures++; $display("FAIL addi_alucode act=%0d exp=%0d", bus.alucode, ALU_ADD); end
    checks++; if (bus.imm !== 32'd5) begin failures++; $display("FAIL addi_imm act=%h exp=5", bus.imm); end
    checks++; if (bus.rd !== 5'd1) begin failures++; $display("FAIL addi_rd act=%0d exp=1", bus.rd); end
    checks++; if (bus.op1_sel !== 2'd0 || bus.op2_sel !== 2'd1) begin failures++; $display("FAIL addi_sel act=%0d/%0d exp=0/1", bus.op1_sel, bus.op2_sel); end
    checks++; if (bus.reg_we !== 1'b1) begin failures++; $display("FAIL addi_reg_we act=%0d exp=1", bus.reg_we); end
    checks++; if (bus.decode_cnt !== 32'd1) begin failures++; $display("FAIL addi_cnt act=%0d exp=1", bus.decode_cnt); end
  endtask

  task automatic test_branch();
    drive(1'b1, 32'h4, 32'h00208463, 1'b1);
    step();
    exp_cnt = exp_cnt + 1;
    checks++; if (bus.alucode !== ALU_BEQ) begin failures++; $display("FAIL beq_alucode act=%0d exp=%0d", bus.alucode, ALU_BEQ); end
    checks++; if (bus.imm !== 32'd8) begin failures++; $display("FAIL beq_imm act=%h exp=8", bus.imm); end
    checks++; if (bus.reg_we !== 1'b0) begin failures++; $display("FAIL beq_reg_we act=%0d exp=0", bus.reg_we); end
    checks++; if (bus.rs1 !== 5'd1 || bus.rs2 !== 5'd2) begin failures++; $display("FAIL beq_rs act=%0d/%0d exp=1/2", bus.rs1, bus.rs2); end
    checks++; if (bus.op1_sel !== 2'd0 || bus.op2_sel !== 2'd0) begin failures++; $display("FAIL beq_sel act=%0d/%0d exp=0/0", bus.op1_sel, bus.op2_sel); end
  endtask

  task automatic test_jal();
    drive(1'b1, 32'h100, 32'h010000EF, 1'b1);
    step();
    exp_cnt = exp_cnt + 1;
    checks++; if (bus.alucode !== ALU_JAL) begin failures++; $display("FAIL jal_alucode act=%0d exp=%0d", bus.alucode, ALU_JAL); end
    checks++; if (bus.imm !== 32'd16) begin failures++; $display("FAIL jal_imm act=%h exp=10", bus.imm); end
    checks++; if (bus.op2_sel !== 2'd2) begin failures++; $display("FAIL jal_op2_sel act=%0d exp=2", bus.op2_sel); end
    checks++; if (bus.out_pc !== 32'h100) begin failures++; $display("FAIL jal_pc act=%h exp=100", bus.out_pc); end
    checks++; if (bus.decode_cnt !== exp_cnt) begin failures++; $display("FAIL jal_cnt act=%0d exp=%0d", bus.decode_cnt, exp_cnt); end
  endtask

  task automatic test_stall();
    drive(1'b1, 32'h104, 32'h123452B7, 1'b1);
    step();
    exp_cnt = exp_cnt + 1;
    drive(1'b1, 32'h108, 32'h002081B3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d act=%0d exp=0", i, bus.in_ready); end
      step();
      checks++; if (bus.out_valid !== 1'b1 || bus.alucode !== ALU_LUI) begin failures++; $display("FAIL stall_hold cyc=%0d valid=%0d alucode=%0d exp=1/%0d", i, bus.out_valid, bus.alucode, ALU_LUI); end
      checks++; if (bus.imm !== 32'h12345000 || bus.rd !== 5'd5 || bus.op2_sel !== 2'd1) begin failures++; $display("FAIL stall_fields cyc=%0d imm=%h rd=%0d op2=%0d exp=12345000/5/1", i, bus.imm, bus.rd, bus.op2_sel); end
      checks++; if (bus.out_pc !== 32'h104 || bus.decode_cnt !== exp_cnt) begin failures++; $display("FAIL stall_pc_cnt cyc=%0d pc=%h cnt=%0d exp=104/%0d", i, bus.out_pc, bus.decode_cnt, exp_cnt); end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready act=%0d exp=1", bus.in_ready); end
    step();
    exp_cnt = exp_cnt + 1;
    checks++; if (bus.out_valid !== 1'b1 || bus.alucode !== ALU_ADD) begin failures++; $display("FAIL release_add valid=%0d alucode=%0d exp=1/%0d", bus.out_valid, bus.alucode, ALU_ADD); end
    checks++; if (bus.rd !== 5'd3 || bus.rs1 !== 5'd1 || bus.rs2 !== 5'd2 || bus.op2_sel !== 2'd0) begin failures++; $display("FAIL release_fields rd=%0d rs1=%0d rs2=%0d op2=%0d exp=3/1/2/0", bus.rd, bus.rs1, bus.rs2, bus.op2_sel); end
    checks++; if (bus.out_pc !== 32'h108 || bus.decode_cnt !== exp_cnt) begin failures++; $display("FAIL release_pc_cnt pc=%h cnt=%0d exp=108/%0d", bus.out_pc, bus.decode_cnt, exp_cnt); end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h10C, 32'h00500093, 1'b0);
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready act=%0d exp=0", bus.in_ready); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid act=%0d exp=0", bus.out_valid); end
    checks++; if (bus.decode_cnt !== exp_cnt) begin failures++; $display("FAIL flush_cnt act=%0d exp=%0d", bus.decode_cnt, exp_cnt); end
    checks++; if (bus.alucode !== ALU_ADD || bus.out_pc !== 32'h108) begin failures++; $display("FAIL flush_hold alucode=%0d pc=%h exp=%0d/108", bus.alucode, bus.out_pc, ALU_ADD); end
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] t_insn [8] = '{32'h40208233, 32'h4030D293, 32'h0020A623, 32'hFFC0A303,
                                32'h00000013, 32'h00001397, 32'hFE209EE3, 32'h004100E7};
    logic [5:0]  t_alu  [8] = '{ALU_SUB, ALU_SRA, ALU_SW, ALU_LW, ALU_ADD, ALU_ADD, ALU_BNE, ALU_JALR};
    logic [31:0] t_imm  [8] = '{32'h0, 32'h403, 32'd12, 32'hFFFFFFFC, 32'h0, 32'h1000, 32'hFFFFFFFC, 32'd4};
    logic [1:0]  t_op1  [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0};
    logic [1:0]  t_op2  [8] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2};
    logic [2:0]  t_flg  [8] = '{3'b100, 3'b100, 3'b001, 3'b110, 3'b000, 3'b100, 3'b000, 3'b100};
    logic [31:0] pc;
    for (int i = 0; i < 8; i++) begin
      pc = 32'h200 + 32'(i) * 4;
      drive(1'b1, pc, t_insn[i], 1'b1);
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready idx=%0d act=%0d exp=1", i, bus.in_ready); end
      step();
      exp_cnt = exp_cnt + 1;
      checks++; if (bus.out_valid !== 1'b1 || bus.alucode !== t_alu[i]) begin failures++; $display("FAIL b2b_alucode idx=%0d valid=%0d act=%0d exp=%0d", i, bus.out_valid, bus.alucode, t_alu[i]); end
      checks++; if (bus.imm !== t_imm[i]) begin failures++; $display("FAIL b2b_imm idx=%0d act=%h exp=%h", i, bus.imm, t_imm[i]); end
      checks++; if (bus.op1_sel !== t_op1[i] || bus.op2_sel !== t_op2[i]) begin failures++; $display("FAIL b2b_sel idx=%0d act=%0d/%0d exp=%0d/%0d", i, bus.op1_sel, bus.op2_sel, t_op1[i], t_op2[i]); end
      checks++; if ({bus.reg_we, bus.is_load, bus.is_store} !== t_flg[i]) begin failures++; $display("FAIL b2b_flags idx=%0d act=%b exp=%b", i, {bus.reg_we, bus.is_load, bus.is_store}, t_flg[i]); end
      checks++; if (bus.out_pc !== pc || bus.decode_cnt !== exp_cnt) begin failures++; $display("FAIL b2b_pc_cnt idx=%0d pc=%h cnt=%0d exp=%h/%0d", i, bus.out_pc, bus.decode_cnt, pc, exp_cnt); end
    end
  endtask

  task automatic test_illegal();
    logic exp_ill;
`ifdef DECODE_ILLEGAL_TRAP_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    drive(1'b1, 32'h300, 32'hFFFFFFFF, 1'b1);
    step();
    exp_cnt = exp_cnt + 1;
    checks++; if (bus.illegal !== exp_ill) begin failures++; $display("FAIL illegal_flag act=%0d exp=%0d", bus.illegal, exp_ill); end
    checks++; if (bus.alucode !== ALU_NOP || bus.out_valid !== 1'b1) begin failures++; $display("FAIL illegal_alucode act=%0d valid=%0d exp=%0d/1", bus.alucode, bus.out_valid, ALU_NOP); end
    checks++; if ({bus.reg_we, bus.is_load, bus.is_store} !== 3'b000) begin failures++; $display("FAIL illegal_flags act=%b exp=000", {bus.reg_we, bus.is_load, bus.is_store}); end
    checks++; if (bus.decode_cnt !== exp_cnt) begin failures++; $display("FAIL illegal_cnt act=%0d exp=%0d", bus.decode_cnt, exp_cnt); end
    drive(1'b1, 32'h304, 32'h00500093, 1'b1);
    step();
    exp_cnt = exp_cnt + 1;
    checks++; if (bus.illegal !== 1'b0 || bus.alucode !== ALU_ADD) begin failures++; $display("FAIL illegal_clear ill=%0d alucode=%0d exp=0/%0d", bus.illegal, bus.alucode, ALU_ADD); end
  endtask

  task automatic test_drain();
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    step();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL drain_out_valid act=%0d exp=0", bus.out_valid); end
    checks++; if (bus.alucode !== ALU_ADD || bus.imm !== 32'd5 || bus.out_pc !== 32'h304) begin failures++; $display("FAIL drain_hold alucode=%0d imm=%h pc=%h exp=%0d/5/304", bus.alucode, bus.imm, bus.out_pc, ALU_ADD); end
    checks++; if (bus.decode_cnt !== exp_cnt) begin failures++; $display("FAIL drain_cnt act=%0d exp=%0d", bus.decode_cnt, exp_cnt); end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 32'h400, 32'h123452B7, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.decode_cnt !== 32'd0) begin failures++; $display("FAIL midrst_state valid=%0d cnt=%0d exp=0/0", bus.out_valid, bus.decode_cnt); end
    checks++; if (bus.out_pc !== TB_RESET_PC || bus.alucode !== ALU_NOP || bus.imm !== 32'd0) begin failures++; $display("FAIL midrst_fields pc=%h alucode=%0d imm=%h exp=%h/%0d/0", bus.out_pc, bus.alucode, bus.imm, TB_RESET_PC, ALU_NOP); end
    step();
    rst_n = 1'b1;
    drive(1'b1, 32'h500, 32'h00500093, 1'b1);
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.decode_cnt !== 32'd1 || bus.out_pc !== 32'h500) begin failures++; $display("FAIL midrst_first valid=%0d cnt=%0d pc=%h exp=1/1/500", bus.out_valid, bus.decode_cnt, bus.out_pc); end
    drive(1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = 32'd0;
    test_reset();
    test_addi();
    test_branch();
    test_jal();
    test_stall();
    test_flush();
    test_back_to_back();
    test_illegal();
    test_drain();
    test_mid_reset();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
